// File: rtl/audio_dac_tx_if.sv
// Sample handshake bundle between the audio sample source and audio_dac_tx.
// The source drives a stereo pair with valid; the transmitter answers with ready.
interface audio_dac_tx_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  iSAMPLE_VALID;
    logic [DATA_WIDTH-1:0] iLEFT;
    logic [DATA_WIDTH-1:0] iRIGHT;
    logic                  oSAMPLE_READY;

    modport master (
        output iSAMPLE_VALID,
        output iLEFT,
        output iRIGHT,
        input  oSAMPLE_READY
    );

    modport slave (
        input  iSAMPLE_VALID,
        input  iLEFT,
        input  iRIGHT,
        output oSAMPLE_READY
    );
endinterface

// File: rtl/audio_dac_tx.sv
// Serial audio DAC transmitter, slaved to externally generated LRCK/BCK.
// Buffers one stereo pair and shifts it MSB-first onto DACDAT, left-justified,
// with data changing one iCLK after each BCK falling edge.
// Optional build macro AUDIO_DAC_TX_I2S_DELAY_EN: delays the serial stream by
// one BCK slot through an extra register, giving I2S framing.
module audio_dac_tx #(
    parameter int DATA_WIDTH    = 16,
    parameter int UNDERRUN_ZERO = 1
) (
    input  logic                 iCLK,
    input  logic                 iRST_N,
    input  logic                 iAUD_BCK,
    input  logic                 iAUD_LRCK,
    audio_dac_tx_if.slave        smp,
    output logic                 oAUD_DACDAT,
    output logic                 oFRAME_START,
    output logic                 oUNDERRUN
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  full_q, full_d;
    logic [DATA_WIDTH-1:0] bufLeft_q, bufLeft_d;
    logic [DATA_WIDTH-1:0] bufRight_q, bufRight_d;
    logic [DATA_WIDTH-1:0] shiftLeft_q, shiftLeft_d;
    logic [DATA_WIDTH-1:0] shiftRight_q, shiftRight_d;
    logic [DATA_WIDTH-1:0] lastLeft_q, lastLeft_d;
    logic [DATA_WIDTH-1:0] lastRight_q, lastRight_d;
    logic [CW-1:0]         bitCnt_q, bitCnt_d;
    logic                  dac_q, dac_d;
    logic                  frameStart_q, frameStart_d;
    logic                  underrun_q, underrun_d;
    logic                  bck_q;
    logic                  lrck_q;

    logic                  bckFall;
    logic                  lrFall;
    logic                  lrRise;
    logic                  accept;
    logic [DATA_WIDTH-1:0] loadLeft;
    logic [DATA_WIDTH-1:0] loadRight;

    assign bckFall = bck_q & ~iAUD_BCK;
    assign lrFall  = lrck_q & ~iAUD_LRCK;
    assign lrRise  = ~lrck_q & iAUD_LRCK;

    // Ready is forced low during reset so no pair is taken before the buffer is cleared.
    assign smp.oSAMPLE_READY = ~full_q & ~iRST_N;
    assign accept            = smp.iSAMPLE_VALID & smp.oSAMPLE_READY;

    // State register plus edge history; everything clears on synchronous reset.
    always_ff @(posedge iCLK) begin
        if (iRST_N) begin
            state_q      <= IDLE;
            full_q       <= 1'b0;
            bufLeft_q    <= '0;
            bufRight_q   <= '0;
            shiftLeft_q  <= '0;
            shiftRight_q <= '0;
            lastLeft_q   <= '0;
            lastRight_q  <= '0;
            bitCnt_q     <= '0;
            dac_q        <= 1'b0;
            frameStart_q <= 1'b0;
            underrun_q   <= 1'b0;
            bck_q        <= 1'b0;
            lrck_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            full_q       <= full_d;
            bufLeft_q    <= bufLeft_d;
            bufRight_q   <= bufRight_d;
            shiftLeft_q  <= shiftLeft_d;
            shiftRight_q <= shiftRight_d;
            lastLeft_q   <= lastLeft_d;
            lastRight_q  <= lastRight_d;
            bitCnt_q     <= bitCnt_d;
            dac_q        <= dac_d;
            frameStart_q <= frameStart_d;
            underrun_q   <= underrun_d;
            bck_q        <= iAUD_BCK;
            lrck_q       <= iAUD_LRCK;
        end
    end

    // Next state: LRCK edges take priority over BCK so a misaligned phase resyncs each half-frame;
    // a same-cycle handshake is applied after the load so the load sees the old buffer.
    always_comb begin
        state_d      = state_q;
        full_d       = full_q;
        bufLeft_d    = bufLeft_q;
        bufRight_d   = bufRight_q;
        shiftLeft_d  = shiftLeft_q;
        shiftRight_d = shiftRight_q;
        lastLeft_d   = lastLeft_q;
        lastRight_d  = lastRight_q;
        bitCnt_d     = bitCnt_q;
        dac_d        = dac_q;
        frameStart_d = 1'b0;
        underrun_d   = 1'b0;
        loadLeft     = '0;
        loadRight    = '0;

        if (lrFall) begin
            if (full_q) begin
                loadLeft    = bufLeft_q;
                loadRight   = bufRight_q;
                lastLeft_d  = bufLeft_q;
                lastRight_d = bufRight_q;
                full_d      = 1'b0;
            end else begin
                underrun_d = 1'b1;
                if (UNDERRUN_ZERO == 0) begin
                    loadLeft  = lastLeft_q;
                    loadRight = lastRight_q;
                end
            end
            shiftLeft_d  = loadLeft;
            shiftRight_d = loadRight;
            dac_d        = loadLeft[DATA_WIDTH-1];
            bitCnt_d     = CNT_ONE;
            frameStart_d = 1'b1;
            state_d      = LEFT;
        end else begin
            unique case (state_q)
                IDLE: begin
                    dac_d = 1'b0;
                end
                LEFT: begin
                    if (lrRise) begin
                        dac_d    = shiftRight_q[DATA_WIDTH-1];
                        bitCnt_d = CNT_ONE;
                        state_d  = RIGHT;
                    end else if (bckFall && (bitCnt_q < CNT_FULL)) begin
                        dac_d       = shiftLeft_q[DATA_WIDTH-2];
                        shiftLeft_d = shiftLeft_q << 1;
                        bitCnt_d    = bitCnt_q + 1'b1;
                    end
                end
                RIGHT: begin
                    if (bckFall && (bitCnt_q < CNT_FULL)) begin
                        dac_d        = shiftRight_q[DATA_WIDTH-2];
                        shiftRight_d = shiftRight_q << 1;
                        bitCnt_d     = bitCnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (accept) begin
            bufLeft_d  = smp.iLEFT;
            bufRight_d = smp.iRIGHT;
            full_d     = 1'b1;
        end
    end

`ifdef AUDIO_DAC_TX_I2S_DELAY_EN
    logic i2sBit_q;

    // One-slot delay: takes the previous serial bit at every BCK fall and LRCK edge.
    always_ff @(posedge iCLK) begin
        if (iRST_N) begin
            i2sBit_q <= 1'b0;
        end else if (bckFall || lrFall || lrRise) begin
            i2sBit_q <= dac_q;
        end
    end

    assign oAUD_DACDAT = i2sBit_q;
`else
    assign oAUD_DACDAT = dac_q;
`endif

    assign oFRAME_START = frameStart_q;
    assign oUNDERRUN    = underrun_q;

endmodule

// File: tb/tb_audio_dac_tx.sv
// Testbench for audio_dac_tx: two instances (zero-fill and repeat-last underrun)
// fed from one sample source and one LRCK/BCK generator.
module tb_audio_dac_tx;

    logic iCLK;
    logic iRST_N;
    logic bck;
    logic lrck;
    logic sampleValid;
    logic [15:0] sampleLeft;
    logic [15:0] sampleRight;
    logic dac0, dac1, fs0, fs1, ur0, ur1;

    audio_dac_tx_if #(.DATA_WIDTH(16)) smpIf0 ();
    audio_dac_tx_if #(.DATA_WIDTH(16)) smpIf1 ();

    assign smpIf0.iSAMPLE_VALID = sampleValid;
    assign smpIf0.iLEFT         = sampleLeft;
    assign smpIf0.iRIGHT        = sampleRight;
    assign smpIf1.iSAMPLE_VALID = sampleValid;
    assign smpIf1.iLEFT         = sampleLeft;
    assign smpIf1.iRIGHT        = sampleRight;

    audio_dac_tx #(.DATA_WIDTH(16), .UNDERRUN_ZERO(1)) dut0 (
        .iCLK(iCLK), .iRST_N(iRST_N), .iAUD_BCK(bck), .iAUD_LRCK(lrck),
        .smp(smpIf0), .oAUD_DACDAT(dac0), .oFRAME_START(fs0), .oUNDERRUN(ur0)
    );

    audio_dac_tx #(.DATA_WIDTH(16), .UNDERRUN_ZERO(0)) dut1 (
        .iCLK(iCLK), .iRST_N(iRST_N), .iAUD_BCK(bck), .iAUD_LRCK(lrck),
        .smp(smpIf1), .oAUD_DACDAT(dac1), .oFRAME_START(fs1), .oUNDERRUN(ur1)
    );

    typedef struct {
        logic        offer;
        logic [15:0] left;
        logic [15:0] right;
        logic        expUnderrun;
        logic [31:0] expWord0;
        logic [31:0] expWord1;
    } vec_t;

    vec_t vecs [6];

    int numCompared;
    int numMismatched;
    int p;
    int bckOff;
    logic genEn;
    logic bckPrev;
    logic [31:0] capAcc0, capAcc1, capDone0, capDone1;
    int fsCnt;
    int urCnt;
    logic [31:0] prev0, prev1;

    // System clock.
    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // Clock generator model (BCK = iCLK/36, LRCK = iCLK/1152) plus capture of DACDAT on BCK rises.
    always @(negedge iCLK) begin
        if (genEn) begin
            p    = (p == 1151) ? 0 : p + 1;
            bck  = (((p + bckOff) % 36) >= 18);
            lrck = (p >= 576);
            if (p == 0) begin
                capDone0 = capAcc0;
                capDone1 = capAcc1;
                capAcc0  = '0;
                capAcc1  = '0;
            end
            if (bck && !bckPrev) begin
                capAcc0 = {capAcc0[30:0], dac0};
                capAcc1 = {capAcc1[30:0], dac1};
            end
            bckPrev = bck;
        end
    end

    // Pulse counters for the whole run.
    always @(negedge iCLK) begin
        if (fs0) fsCnt++;
        if (ur0) urCnt++;
    end

    function automatic logic [31:0] frameExp(input logic [31:0] cur, input logic [31:0] prev);
        logic [31:0] r;
        r = cur;
`ifdef AUDIO_DAC_TX_I2S_DELAY_EN
        r = {prev[0], cur[31:1]};
`endif
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        numCompared++;
        if (actual !== expected) begin
            numMismatched++;
            $display("[TB] FAIL %s: actual %h required %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input string name, input logic [15:0] l, input logic [15:0] r);
        int n;
        n = 0;
        sampleLeft  = l;
        sampleRight = r;
        sampleValid = 1'b1;
        while (!smpIf0.oSAMPLE_READY && n < 1400) begin
            @(negedge iCLK);
            n++;
        end
        checkOutput({name, "_accept"}, {31'b0, smpIf0.oSAMPLE_READY}, 32'd1);
        @(posedge iCLK);
        #1 sampleValid = 1'b0;
    endtask

    task automatic waitFrameStart(input string name);
        int n;
        n = 0;
        do begin
            @(negedge iCLK);
            n++;
        end while (!fs0 && n < 1400);
        checkOutput({name, "_frame_start"}, {31'b0, fs0}, 32'd1);
    endtask

    initial begin
        logic sawActivity;
        numCompared   = 0;
        numMismatched = 0;
        fsCnt         = 0;
        urCnt         = 0;
        sampleValid   = 1'b0;
        sampleLeft    = '0;
        sampleRight   = '0;
        genEn         = 1'b0;
        bckOff        = 0;
        p             = 600;
        bck           = ((p % 36) >= 18);
        lrck          = (p >= 576);
        bckPrev       = bck;
        capAcc0       = '0;
        capAcc1       = '0;
        capDone0      = '0;
        capDone1      = '0;
        prev0         = '0;
        prev1         = '0;
        iRST_N        = 1'b1;

        vecs[0] = '{1'b1, 16'hA5C3, 16'h3C5A, 1'b0, 32'hA5C33C5A, 32'hA5C33C5A};
        vecs[1] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 32'h00000000, 32'hA5C33C5A};
        vecs[2] = '{1'b1, 16'h8001, 16'h7FFE, 1'b0, 32'h80017FFE, 32'h80017FFE};
        vecs[3] = '{1'b1, 16'hFFFF, 16'h0000, 1'b0, 32'hFFFF0000, 32'hFFFF0000};
        vecs[4] = '{1'b1, 16'h1234, 16'hABCD, 1'b0, 32'h1234ABCD, 32'h1234ABCD};
        vecs[5] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 32'h00000000, 32'h1234ABCD};

        // Reset held, then idle with no LRCK activity.
        repeat (5) @(negedge iCLK);
        checkOutput("reset_ready", {31'b0, smpIf0.oSAMPLE_READY}, 32'd0);
        checkOutput("reset_dacdat", {31'b0, dac0}, 32'd0);
        iRST_N = 1'b0;
        @(negedge iCLK);
        checkOutput("release_ready", {31'b0, smpIf0.oSAMPLE_READY}, 32'd1);
        sawActivity = 1'b0;
        repeat (20) begin
            @(negedge iCLK);
            sawActivity = sawActivity | fs0 | ur0 | dac0 | fs1 | ur1 | dac1;
        end
        checkOutput("idle_quiet", {31'b0, sawActivity}, 32'd0);
        genEn = 1'b1;

        // Table-driven frames: offer (or not) before each frame, check pulses and the previous frame.
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].offer) applyStimulus($sformatf("v%0d", i), vecs[i].left, vecs[i].right);
            waitFrameStart($sformatf("v%0d", i));
            checkOutput($sformatf("v%0d_underrun0", i), {31'b0, ur0}, {31'b0, vecs[i].expUnderrun});
            checkOutput($sformatf("v%0d_underrun1", i), {31'b0, ur1}, {31'b0, vecs[i].expUnderrun});
            if (i > 0) begin
                checkOutput($sformatf("v%0d_word0", i - 1), capDone0, frameExp(vecs[i-1].expWord0, prev0));
                checkOutput($sformatf("v%0d_word1", i - 1), capDone1, frameExp(vecs[i-1].expWord1, prev1));
                prev0 = vecs[i-1].expWord0;
                prev1 = vecs[i-1].expWord1;
            end
            if (i == 0) begin
                @(negedge iCLK);
                checkOutput("frame_start_one_cycle", {31'b0, fs0}, 32'd0);
            end
        end

        // Backpressure: second pair waits until the next frame load frees the buffer.
        applyStimulus("bp_first", 16'h5555, 16'hAAAA);
        sampleLeft  = 16'h0F0F;
        sampleRight = 16'hF0F0;
        sampleValid = 1'b1;
        @(negedge iCLK);
        checkOutput("bp_ready_low_while_full", {31'b0, smpIf0.oSAMPLE_READY}, 32'd0);
        begin
            int n;
            n = 0;
            while (!smpIf0.oSAMPLE_READY && n < 1400) begin
                @(negedge iCLK);
                n++;
            end
        end
        checkOutput("bp_ready_at_load", {31'b0, fs0}, 32'd1);
        checkOutput("bp_no_underrun", {31'b0, ur0}, 32'd0);
        checkOutput("v5_word0", capDone0, frameExp(vecs[5].expWord0, prev0));
        checkOutput("v5_word1", capDone1, frameExp(vecs[5].expWord1, prev1));
        prev0 = vecs[5].expWord0;
        prev1 = vecs[5].expWord1;
        @(posedge iCLK);
        #1 sampleValid = 1'b0;

        waitFrameStart("bp_second");
        checkOutput("bp_second_underrun", {31'b0, ur0}, 32'd0);
        checkOutput("bp_first_word0", capDone0, frameExp(32'h5555AAAA, prev0));
        checkOutput("bp_first_word1", capDone1, frameExp(32'h5555AAAA, prev1));
        prev0 = 32'h5555AAAA;
        prev1 = 32'h5555AAAA;

        // Misaligned BCK: shift the phase mid-frame, expect a clean frame after the next LRCK fall.
        bckOff = 5;
        applyStimulus("mis", 16'hC001, 16'h8003);
        waitFrameStart("mis_load");
        checkOutput("mis_load_underrun", {31'b0, ur0}, 32'd0);
        prev0 = 32'h0F0FF0F0;
        prev1 = 32'h0F0FF0F0;
        waitFrameStart("mis_after");
        checkOutput("mis_after_underrun0", {31'b0, ur0}, 32'd1);
        checkOutput("mis_after_underrun1", {31'b0, ur1}, 32'd1);
        checkOutput("mis_word0", capDone0, frameExp(32'hC0018003, prev0));
        checkOutput("mis_word1", capDone1, frameExp(32'hC0018003, prev1));

        #2;
        checkOutput("frame_start_count", fsCnt, 32'd10);
        checkOutput("underrun_count", urCnt, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
